// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command stream to single AMBA 3 APB transfers
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake; cmd_write/cmd_addr/cmd_wdata sampled on it
//   rsp_valid/rsp_ready             response handshake; rsp_rdata/rsp_err held while rsp_valid
//   busy                            high whenever the bridge is not IDLE
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  registered APB initiator outputs
//   PRDATA/PREADY/PSLVERR           APB completer inputs, sampled only in ACCESS with PREADY
//
// Optional: define APB_MASTER_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES
// ACCESS cycles with PREADY low (response rsp_err=1, rsp_rdata=0).
module apb_master_bridge #(
    parameter int APB_AW         = 32,
    parameter int APB_DW         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [APB_AW-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_AW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   cmd_fire;
    logic   access_done;
    logic   access_abort;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign access_done = (state == S_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Abort fires on the TIMEOUT_CYCLES-th wait cycle, i.e. as the count reaches TIMEOUT_CYCLES.
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;

    // Cleared in SETUP so it starts at zero on the first ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == S_ACCESS) && !PREADY) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // PREADY in the same cycle wins over the abort.
    assign access_abort = (state == S_ACCESS) && !PREADY && (wait_cnt == WAIT_LAST);
`else
    // Constant false: ACCESS waits for PREADY indefinitely.
    assign access_abort = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cmd_valid)               state_nxt = S_SETUP;
            S_SETUP:                               state_nxt = S_ACCESS;
            S_ACCESS: if (PREADY || access_abort)  state_nxt = S_RESP;
            S_RESP:   if (rsp_ready)               state_nxt = S_IDLE;
            default:                               state_nxt = S_IDLE;
        endcase
    end

    // Stream-side outputs decoded from state; cmd_ready is held low while in reset.
    always_comb begin
        cmd_ready = (state == S_IDLE) && rst_n;
        rsp_valid = (state == S_RESP);
        busy      = (state != S_IDLE);
    end

    // APB control registered from the next state so PSEL/PENABLE line up with SETUP/ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end else begin
            PSEL    <= (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
            PENABLE <= (state_nxt == S_ACCESS);
        end
    end

    // Transfer attributes change only on command acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (cmd_fire) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
        end
    end

    // Response captured once at completion and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else if (access_abort) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
        end else if (access_done) begin
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
        end
    end

endmodule
